debug_dump_ctrl: RTL and testbench
==================================

DEBUG_DUMP_CTRL -- requirements
Module: debug_dump_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1 bit: system clock; all state updates on the rising edge.
REQ-002 SHALL have `rst`, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have `start`, input, 1 bit: single-cycle dump request from the debug command decoder.
REQ-004 SHALL have `sel_code`, output, 7 bits: selector code driven to the pipeline latch mux.
REQ-005 SHALL have `sel_data`, input, 32 bits: registered mux output, valid 1 cycle after `sel_code` is sampled.
REQ-006 SHALL have `tx_data`, output, 8 bits: byte offered to the UART transmitter.
REQ-007 SHALL have `tx_valid`, output, 1 bit: byte offer; a transfer occurs on any cycle where `tx_valid` and `tx_ready` are both 1.
REQ-008 SHALL have `tx_ready`, input, 1 bit: UART transmitter can accept a byte.
REQ-009 SHALL have `busy`, output, 1 bit: high while a dump is in progress.
REQ-010 SHALL have `pipe_en`, output, 1 bit: pipeline clock enable; low while `busy` so latch contents are frozen.
REQ-011 SHALL have `done`, output, 1 bit: one-cycle pulse after the last byte transfers.

Function
REQ-012 SHALL walk a fixed 20-entry code table, in this order:
- 0x00, 0x01
- 0x10–0x15
- 0x20, 0x21, 0x23, 0x24, 0x25, 0x26
- 0x30–0x33
- 0x40, 0x41
REQ-013 SHALL implement the states IDLE, SELECT, WAIT, CAPTURE, SEND, NEXT, DONE.
REQ-014 IDLE: `start`=1 SHALL move to SELECT with index 0; `start` in any other state SHALL be ignored.
REQ-015 SELECT SHALL drive `sel_code`=table[index] and go to WAIT; `sel_code` SHALL hold that value through WAIT and CAPTURE.
REQ-016 WAIT SHALL last exactly one cycle, covering the mux register latency.
REQ-017 CAPTURE SHALL load `sel_data` into a 32-bit shift register, clear the byte counter, and go to SEND.
REQ-018 SEND SHALL present the word MSB byte first (bits 31:24, then 23:16, 15:8, 7:0) with `tx_valid`=1.
REQ-019 While `tx_valid`=1 and `tx_ready`=0, `tx_data` SHALL remain stable and `tx_valid` SHALL stay high.
REQ-020 On each transfer the controller SHALL shift 8 bits; after the 4th transfer it SHALL go to NEXT.
REQ-021 NEXT SHALL go to SELECT with index+1 when index<19; when index=19 it SHALL go to DONE (no wrap).
REQ-022 DONE SHALL pulse `done` for 1 cycle and return to IDLE.
REQ-023 `busy` SHALL be 1 in every state except IDLE; `pipe_en` SHALL equal NOT `busy`.
REQ-024 Minimum dump time with `tx_ready` held at 1 SHALL be 20×(1+1+1+4+1)+1 = 161 cycles after the `start` cycle.
REQ-025 Outside SEND, `tx_valid` SHALL be 0; in IDLE, `sel_code` SHALL hold 0x00.

Reset
REQ-026 Asserting `rst` SHALL immediately force IDLE, index=0, shift register=0, `sel_code`=0x00, `tx_data`=0x00, `tx_valid`=0, `busy`=0, `done`=0, `pipe_en`=1.
REQ-027 Reset mid-dump SHALL abandon the frame without completing the current byte; after release, the next `start` SHALL begin at table index 0.

Configuration
REQ-028 With `DEBUG_DUMP_HEADER_EN` defined, a HEADER state SHALL precede the first SELECT, sending 0xA5 then 0x14 (entry count) under the same handshake rules.
- This gives 82 bytes per dump and a minimum of 163 cycles.
REQ-029 With `DEBUG_DUMP_HEADER_EN` undefined, no header SHALL be sent, giving 80 bytes per dump.

Structure
REQ-030 A shared package `debug_pkg` SHALL hold:
- the state enum
- the 20-entry code table constant
- `DUMP_ENTRIES`=20
- `HDR_SYNC`=8'hA5
REQ-031 SHALL contain one sub-module, `byte_serializer`: 32-bit load, 4-byte valid/ready output, `last` flag; the FSM stays in the top level.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Model mux returns {1'b0,code,24'hC0FFEE}; `tx_ready`=1; pulse `start` -> exactly 80 bytes, first four 0x00,0xC0,0xFF,0xEE; `done` at cycle 161; `busy` and `pipe_en` complementary throughout.
- `tx_ready` toggling 1-0-1-0 -> same 80-byte sequence; `tx_data` unchanged across every stall cycle.
- `start` pulsed again at cycle 50 of a dump -> ignored; still exactly 80 bytes and one `done`.
- `rst` asserted at byte 30 -> `tx_valid`=0 and `pipe_en`=1 immediately; the following `start` emits byte 0 for code 0x00.
- Check the `sel_code` trace -> exactly the 20 table codes in order; 0x22 never driven.
- `DEBUG_DUMP_HEADER_EN` defined -> first bytes 0xA5, 0x14; 82 bytes total; `done` at cycle 163.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump controller: FSM states, the selector
// code table walked on every dump, and the optional header constants.
package debug_pkg;

    localparam int DUMP_ENTRIES = 20;
    localparam int IDX_W        = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_ENTRIES - 1);

    localparam logic [7:0] HDR_SYNC  = 8'hA5;
    localparam logic [7:0] HDR_COUNT = 8'(DUMP_ENTRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SELECT,
        ST_WAIT,
        ST_CAPTURE,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Entry 0 sits in the least significant slot, so the list reads backwards.
    // 0x22 is deliberately absent: that selector has no latch behind it.
    localparam logic [DUMP_ENTRIES-1:0][6:0] CODE_TABLE = {
        7'h41, 7'h40,
        7'h33, 7'h32, 7'h31, 7'h30,
        7'h26, 7'h25, 7'h24, 7'h23, 7'h21, 7'h20,
        7'h15, 7'h14, 7'h13, 7'h12, 7'h11, 7'h10,
        7'h01, 7'h00
    };

endpackage

// File: rtl/byte_serializer.sv
// Holds one captured 32-bit word and offers it MSB byte first on a
// valid/ready interface; 'last' marks the fourth byte of the word.
module byte_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        valid,
    output logic        last
);

    logic [31:0] shreg;
    logic [1:0]  cnt;
    logic        active;

    // Load a new word, or shift one byte out on each accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= word;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active && ready) begin
            shreg <= {shreg[23:0], 8'h00};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3)
                active <= 1'b0;
        end
    end

    // The offered byte is always the top of the shift register, so it is
    // naturally stable while the consumer stalls.
    always_comb begin
        data  = shreg[31:24];
        valid = active;
        last  = (cnt == 2'd3);
    end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Debug dump controller: on 'start', freezes the pipeline and walks the
// selector code table, capturing each latch word and streaming it to the
// UART as four bytes, MSB first.
// Build option: DEBUG_DUMP_HEADER_EN prepends a two-byte header
// (sync 0xA5, entry count) ahead of the first entry.
module debug_dump_ctrl
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [6:0]  sel_code,
    input  logic [31:0] sel_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        pipe_en,
    output logic        done
);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;

    logic       ser_load;
    logic       ser_ready;
    logic [7:0] ser_data;
    logic       ser_valid;
    logic       ser_last;

`ifdef DEBUG_DUMP_HEADER_EN
    // Which header byte is on offer: 0 = sync, 1 = entry count.
    logic hdr_cnt;

    // Advance through the two header bytes as each one is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hdr_cnt <= 1'b0;
        else if (state == ST_HEADER && tx_ready)
            hdr_cnt <= ~hdr_cnt;
    end
`endif

    // State, index and selector registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Selector code is registered so the mux sees a clean value; it is loaded
    // on entry to SELECT and held until the next entry or the return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sel_code <= '0;
        else if (state_next == ST_SELECT)
            sel_code <= CODE_TABLE[idx_next];
        else if (state_next == ST_IDLE)
            sel_code <= '0;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        ser_load   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    idx_next = '0;
`ifdef DEBUG_DUMP_HEADER_EN
                    state_next = ST_HEADER;
`else
                    state_next = ST_SELECT;
`endif
                end
            end
`ifdef DEBUG_DUMP_HEADER_EN
            ST_HEADER: begin
                if (tx_ready && hdr_cnt)
                    state_next = ST_SELECT;
            end
`endif
            ST_SELECT:  state_next = ST_WAIT;
            // One cycle for the registered mux to reflect the new code.
            ST_WAIT:    state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                ser_load   = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (ser_valid && tx_ready && ser_last)
                    state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = ST_SELECT;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        pipe_en = ~busy;
    end

    // Byte offer mux: serializer during SEND, fixed header bytes in HEADER.
    always_comb begin
        ser_ready = tx_ready && (state == ST_SEND);
        tx_valid  = ser_valid && (state == ST_SEND);
        tx_data   = ser_data;
`ifdef DEBUG_DUMP_HEADER_EN
        if (state == ST_HEADER) begin
            tx_valid = 1'b1;
            tx_data  = hdr_cnt ? HDR_COUNT : HDR_SYNC;
        end
`endif
    end

    byte_serializer u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_load),
        .word  (sel_data),
        .ready (ser_ready),
        .data  (ser_data),
        .valid (ser_valid),
        .last  (ser_last)
    );

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Directed bench for debug_dump_ctrl: a model mux returns
// {1'b0, code, 24'hC0FFEE}; dumps are run with steady and toggling ready,
// a stray start, and a mid-dump reset, and the byte stream is scored.
module tb_debug_dump_ctrl;

`ifdef DEBUG_DUMP_HEADER_EN
    localparam int HOFF = 2;
`else
    localparam int HOFF = 0;
`endif
    localparam int NBYTES  = 80 + HOFF;
    localparam int DONE_AT = 161 + HOFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  sel_code;
    logic [31:0] sel_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        pipe_en;
    logic        done;

    debug_dump_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel_code (sel_code),
        .sel_data (sel_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .pipe_en  (pipe_en),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Registered mux model.
    always @(posedge clk) sel_data <= {1'b0, sel_code, 24'hC0FFEE};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [6:0] codes [20] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
                               7'h20, 7'h21, 7'h23, 7'h24, 7'h25, 7'h26,
                               7'h30, 7'h31, 7'h32, 7'h33, 7'h40, 7'h41};
    logic [7:0] exp_q [$];

    typedef struct {
        string      name;
        int         pos;
        logic [7:0] exp;
    } spot_t;
    spot_t spots [10];

    // Monitor state
    logic [7:0] bytes [$];
    logic [6:0] trace [$];
    int   t0 = 0, done_cnt = 0, done_cyc = -1, last_sel = -1;
    int   pipe_fail = 0, stall_fail = 0, stall_seen = 0, saw22 = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pipe_en !== ~busy) pipe_fail++;
            if (tx_valid && tx_ready) bytes.push_back(tx_data);
            if (prev_valid && !prev_ready) begin
                stall_seen++;
                if (!tx_valid || tx_data !== prev_data) stall_fail++;
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0;
            end
            if (busy && int'(sel_code) != last_sel) begin
                trace.push_back(sel_code);
                last_sel = int'(sel_code);
            end
            if (sel_code == 7'h22) saw22 = 1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        bytes.delete();
        trace.delete();
        last_sel = -1; done_cnt = 0; done_cyc = -1;
        pipe_fail = 0; stall_fail = 0; stall_seen = 0; saw22 = 0;
    endtask

    // Pulse start, then run until the controller returns to idle (or until
    // the byte count reaches abort_at). extra_start_at re-pulses start.
    task automatic run_dump(input bit toggle, input int extra_start_at,
                            input int abort_at, output bit aborted);
        int  c;
        bit  finished;
        clear_mon();
        aborted  = 1'b0;
        finished = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; tx_ready = 1'b1; t0 = cyc;
        c = 1;
        while (!finished && c < 3000) begin
            @(posedge clk); #1;
            start    = (c == extra_start_at);
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (abort_at >= 0 && bytes.size() >= abort_at) begin
                aborted  = 1'b1;
                finished = 1'b1;
            end else if (!busy) begin
                finished = 1'b1;
            end
            c++;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        check("dump_timeout", {31'd0, finished}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        check({tag, "_count"}, bytes.size(), NBYTES);
        for (int i = 0; i < NBYTES && i < bytes.size(); i++)
            if (bytes[i] !== exp_q[i]) mism++;
        check({tag, "_stream_mism"}, mism, 0);
        check({tag, "_pipe_busy"}, pipe_fail, 0);
    endtask

    initial begin
        bit ab;
        int mism;
`ifdef DEBUG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h14);
`endif
        for (int e = 0; e < 20; e++) begin
            exp_q.push_back({1'b0, codes[e]});
            exp_q.push_back(8'hC0);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hEE);
        end
        spots[0] = '{"b0",  0,  8'h00};
        spots[1] = '{"b1",  1,  8'hC0};
        spots[2] = '{"b2",  2,  8'hFF};
        spots[3] = '{"b3",  3,  8'hEE};
        spots[4] = '{"b4",  4,  8'h01};
        spots[5] = '{"b8",  8,  8'h10};
        spots[6] = '{"b36", 36, 8'h21};
        spots[7] = '{"b40", 40, 8'h23};
        spots[8] = '{"b76", 76, 8'h41};
        spots[9] = '{"b79", 79, 8'hEE};

        // Reset state
        #12;
        check("rst_sel_code", {25'd0, sel_code}, 32'h00);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pipe_en", {31'd0, pipe_en}, 32'd1);
        @(posedge clk); #1; rst = 1'b0;
        idle_cycles(2);

        // Steady ready: full stream, timing, selector trace
        run_dump(1'b0, -1, -1, ab);
        check_stream("steady");
        foreach (spots[i])
            check(spots[i].name,
                  (spots[i].pos + HOFF < bytes.size()) ? {24'd0, bytes[spots[i].pos + HOFF]} : 32'hDEAD,
                  {24'd0, spots[i].exp});
`ifdef DEBUG_DUMP_HEADER_EN
        check("hdr_sync", {24'd0, bytes[0]}, 32'hA5);
        check("hdr_count", {24'd0, bytes[1]}, 32'h14);
`endif
        check("done_cycle", done_cyc, DONE_AT);
        check("done_count", done_cnt, 1);
        check("trace_len", trace.size(), 20);
        mism = 0;
        for (int i = 0; i < 20 && i < trace.size(); i++)
            if (trace[i] !== codes[i]) mism++;
        check("trace_mism", mism, 0);
        check("no_0x22", saw22, 0);
        idle_cycles(2);
        check("idle_sel_code", {25'd0, sel_code}, 32'h00);

        // Toggling ready: same stream, stalled bytes held
        run_dump(1'b1, -1, -1, ab);
        check_stream("toggle");
        check("stall_hold", stall_fail, 0);
        check("stall_seen", {31'd0, stall_seen > 0}, 32'd1);
        check("toggle_done_count", done_cnt, 1);

        // Stray start mid-dump is ignored
        run_dump(1'b0, 50, -1, ab);
        idle_cycles(20);
        check_stream("restart");
        check("restart_done_count", done_cnt, 1);
        check("restart_idle", {31'd0, busy}, 32'd0);

        // Reset at byte 30, then a clean dump from entry 0
        run_dump(1'b0, -1, 30, ab);
        check("abort_reached", {31'd0, ab}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_pipe_en", {31'd0, pipe_en}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sel_code", {25'd0, sel_code}, 32'h00);
        check("abort_tx_data", {24'd0, tx_data}, 32'h00);
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);
        run_dump(1'b0, -1, -1, ab);
        check_stream("post_rst");
        check("post_rst_first", bytes.size() > HOFF ? {24'd0, bytes[HOFF]} : 32'hDEAD, 32'h00);
        check("post_rst_done_cycle", done_cyc, DONE_AT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
